// File: rtl/vga_display_driver_if.sv
`default_nettype none
// ============================================================================
// Module  : vga_display_driver_if
// Brief   : Timer, tile-memory and DAC signals of the tile display driver.
// Revision: 1.0 - initial release
// ============================================================================
interface vga_display_driver_if;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        activevideo;
  logic        hsync_in;
  logic        vsync_in;
  logic [10:0] smem_addr;
  logic [3:0]  charcode;
  logic [11:0] bmem_addr;
  logic [11:0] bmem_color;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hsync;
  logic        vsync;
  logic        frame_tick;
  logic [7:0]  frame_count;

  modport slave (
    input  x, y, activevideo, hsync_in, vsync_in, charcode, bmem_color,
    output smem_addr, bmem_addr, red, green, blue, hsync, vsync,
           frame_tick, frame_count
  );

  modport master (
    output x, y, activevideo, hsync_in, vsync_in, charcode, bmem_color,
    input  smem_addr, bmem_addr, red, green, blue, hsync, vsync,
           frame_tick, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/vga_display_driver.sv
`default_nettype none
// ============================================================================
// Module  : vga_display_driver
// Brief   : Two-stage 16x16 tile renderer (40x30 tiles) with frame counter.
// Revision: 1.0 - initial release
// ============================================================================
module vga_display_driver #(
  parameter int Nchars    = 16,
  parameter int smem_size = 1200,
  parameter int bmem_size = 4096
) (
  input  wire logic           clk,
  input  wire logic           reset,
  vga_display_driver_if.slave bus
);

  localparam int c_char_w  = $clog2(Nchars);
  localparam int c_smem_aw = $clog2(smem_size);
  localparam int c_bmem_aw = $clog2(bmem_size);

  logic [c_smem_aw-1:0] w_smem_addr;
  logic                 w_vs_fall;

  logic [c_smem_aw-1:0] r_smem_addr;
  logic [3:0]           r_xoff;
  logic [3:0]           r_yoff;
  logic                 r_active1;
  logic                 r_hs1;
  logic                 r_vs1;
  logic [11:0]          r_rgb;
  logic                 r_hsync;
  logic                 r_vsync;
  logic [1:0]           r_valid;
  logic                 r_frame_tick;
  logic [7:0]           r_frame_count;

  // row*40 = row*32 + row*8, kept at full address width
  assign w_smem_addr = {bus.y[9:4], 5'b0_0000}
                     + {2'b00, bus.y[9:4], 3'b000}
                     + {5'b0_0000, bus.x[9:4]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_smem_addr <= '0;
      r_xoff      <= 4'h0;
      r_yoff      <= 4'h0;
      r_active1   <= 1'b0;
      r_hs1       <= 1'b1;
      r_vs1       <= 1'b1;
    end else begin
      r_smem_addr <= bus.activevideo ? w_smem_addr : '0;
      r_xoff      <= bus.x[3:0];
      r_yoff      <= bus.y[3:0];
      r_active1   <= bus.activevideo;
      r_hs1       <= bus.hsync_in;
      r_vs1       <= bus.vsync_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb   <= 12'h000;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_rgb   <= r_active1 ? bus.bmem_color : 12'h000;
      r_hsync <= r_hs1;
      r_vsync <= r_vs1;
    end
  end

  // r_vsync holds the previous vs1; the edge only counts once both came from real inputs
  assign w_vs_fall = r_valid[1] & r_vsync & ~r_vs1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid       <= 2'b00;
      r_frame_tick  <= 1'b0;
      r_frame_count <= 8'h00;
    end else begin
      r_valid      <= {r_valid[0], 1'b1};
      r_frame_tick <= w_vs_fall;
      if (w_vs_fall) begin
        r_frame_count <= r_frame_count + 8'h01;
      end
    end
  end

  assign bus.smem_addr   = r_smem_addr;
  assign bus.bmem_addr   = {bus.charcode[c_char_w-1:0], r_yoff, r_xoff};
  assign bus.red         = r_rgb[11:8];
  assign bus.green       = r_rgb[7:4];
  assign bus.blue        = r_rgb[3:0];
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.frame_tick  = r_frame_tick;
  assign bus.frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_display_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_display_driver
// Brief   : Directed self-checking bench for vga_display_driver.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_display_driver;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [7:0] exp_count;

  vga_display_driver_if bus ();

  vga_display_driver #(
    .Nchars    (16),
    .smem_size (1200),
    .bmem_size (4096)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    exp_count       = 8'h00;
    reset           = 1'b1;
    bus.x           = 10'd0;
    bus.y           = 10'd0;
    bus.activevideo = 1'b0;
    bus.hsync_in    = 1'b1;
    bus.vsync_in    = 1'b1;
    bus.charcode    = 4'h0;
    bus.bmem_color  = 12'h000;

    step();
    step();
    check("rst_smem", 32'(bus.smem_addr), 32'd0);
    check("rst_rgb", {20'd0, bus.red, bus.green, bus.blue}, 32'h000);
    check("rst_hsync", 32'(bus.hsync), 32'd1);
    check("rst_vsync", 32'(bus.vsync), 32'd1);
    check("rst_tick", 32'(bus.frame_tick), 32'd0);
    check("rst_count", 32'(bus.frame_count), 32'd0);

    @(negedge clk);
    reset = 1'b0;

    // (50>>4)*40 + (37>>4) = 122; bmem_addr = {5, 50&15, 37&15}
    bus.x = 10'd37; bus.y = 10'd50; bus.activevideo = 1'b1;
    bus.charcode = 4'h5; bus.bmem_color = 12'hABC;
    step();
    check("smem_37_50", 32'(bus.smem_addr), 32'd122);
    check("bmem_525", 32'(bus.bmem_addr), 32'h525);
    step();
    check("red_A", 32'(bus.red), 32'hA);
    check("green_B", 32'(bus.green), 32'hB);
    check("blue_C", 32'(bus.blue), 32'hC);

    bus.x = 10'd47; bus.y = 10'd19; bus.charcode = 4'hF;
    step();
    check("smem_47_19", 32'(bus.smem_addr), 32'd42);
    check("bmem_F3F", 32'(bus.bmem_addr), 32'hF3F);

    bus.x = 10'd639; bus.y = 10'd479;
    step();
    check("smem_max", 32'(bus.smem_addr), 32'd1199);

    bus.x = 10'd700; bus.activevideo = 1'b0; bus.bmem_color = 12'hFFF;
    step();
    check("smem_blank", 32'(bus.smem_addr), 32'd0);
    step();
    check("rgb_blank", {20'd0, bus.red, bus.green, bus.blue}, 32'h000);

    // 96-clock hsync pulse must reappear two edges later, vsync untouched
    for (int i = 0; i < 100; i++) begin
      bus.hsync_in = (i < 96) ? 1'b0 : 1'b1;
      step();
      check("hsync_pulse", 32'(bus.hsync), (i >= 1 && i - 1 < 96) ? 32'd0 : 32'd1);
      check("vsync_quiet", 32'(bus.vsync), 32'd1);
    end
    step();
    step();

    // hsync and vsync fall together
    bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
    exp_count = exp_count + 8'd1;
    step();
    check("both_d1_h", 32'(bus.hsync), 32'd1);
    check("both_d1_v", 32'(bus.vsync), 32'd1);
    check("tick_d1", 32'(bus.frame_tick), 32'd0);
    step();
    check("both_d2_h", 32'(bus.hsync), 32'd0);
    check("both_d2_v", 32'(bus.vsync), 32'd0);
    check("tick_d2", 32'(bus.frame_tick), 32'd1);
    step();
    check("tick_d3", 32'(bus.frame_tick), 32'd0);
    check("count_1", 32'(bus.frame_count), 32'(exp_count));
    bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
    step();
    step();
    step();

    for (int i = 0; i < 255; i++) begin
      bus.vsync_in = 1'b0;
      exp_count = exp_count + 8'd1;
      step();
      bus.vsync_in = 1'b1;
      step();
    end
    step();
    step();
    step();
    check("count_wrap", 32'(bus.frame_count), 32'(exp_count));
    check("count_zero", 32'(bus.frame_count), 32'd0);

    bus.vsync_in = 1'b0;
    step();
    bus.vsync_in = 1'b1;
    step();
    step();
    check("count_after_wrap", 32'(bus.frame_count), 32'd1);

    bus.activevideo = 1'b1; bus.x = 10'd100; bus.y = 10'd100;
    bus.bmem_color = 12'hFFF; bus.hsync_in = 1'b0;
    step();
    step();
    check("pre_rst_rgb", {20'd0, bus.red, bus.green, bus.blue}, 32'hFFF);
    check("pre_rst_hsync", 32'(bus.hsync), 32'd0);

    reset = 1'b1;
    #1;
    check("async_rgb", {20'd0, bus.red, bus.green, bus.blue}, 32'h000);
    check("async_hsync", 32'(bus.hsync), 32'd1);
    check("async_count", 32'(bus.frame_count), 32'd0);
    check("async_smem", 32'(bus.smem_addr), 32'd0);

    // vsync_in held low across reset release
    bus.hsync_in = 1'b1; bus.vsync_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_spurious_tick", 32'(bus.frame_tick), 32'd0);
    end
    check("no_spurious_count", 32'(bus.frame_count), 32'd0);
    bus.vsync_in = 1'b1;
    step();
    step();
    bus.vsync_in = 1'b0;
    step();
    check("rearm_d1", 32'(bus.frame_tick), 32'd0);
    step();
    check("rearm_d2", 32'(bus.frame_tick), 32'd1);
    check("rearm_count", 32'(bus.frame_count), 32'd1);
    step();
    check("rearm_d3", 32'(bus.frame_tick), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
